bv_lookup_ctrl: RTL and testbench
=================================

# bv_lookup_ctrl

Sequencer and arbiter for the bit-vector SRAM bank feeding the per-SRAM AND accumulation stage. It shares the SRAM_NUM single-port SRAMs between search lookups and rule-update writes, and runs a full-bank clear after reset or on request. It also tracks in-flight lookups so that a valid/tag pair emerges aligned with the accumulated match vector.

## Interface
- STRIDE, 4, key bits per SRAM; each SRAM has 2^STRIDE entries
- SRAM_NUM, 4, number of bit-vector SRAMs
- RESULT_WIDTH, 64, bit-vector width (rules)
- SRAM_LAT, 1, SRAM read latency in cycles (≥1)
- TAG_WIDTH, 8, lookup tag width
- MAX_CFG_BURST, 4, maximum consecutive cfg grants while a lookup waits
- Derived constants: KEY_WIDTH = STRIDE*SRAM_NUM; SEL_WIDTH = max(1, clog2(SRAM_NUM))

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- lkp_valid_i / lkp_ready_o  in/out  1  lookup handshake
- lkp_key_i  in  KEY_WIDTH  search key; slice i = key[STRIDE*i +: STRIDE] addresses SRAM i
- lkp_tag_i  in  TAG_WIDTH  opaque tag
- cfg_valid_i / cfg_ready_o  in/out  1  update handshake
- cfg_sram_i  in  SEL_WIDTH  target SRAM index
- cfg_addr_i  in  STRIDE  entry address
- cfg_data_i  in  RESULT_WIDTH  bit-vector to write
- clear_i  in  1  request full-bank clear (level, sampled in RUN)
- clear_done_o  out  1  one-cycle pulse when a clear finishes
- sram_en_o, sram_we_o  out  SRAM_NUM  per-SRAM enable / write enable (registered)
- sram_addr_o  out  STRIDE*SRAM_NUM  per-SRAM address (registered)
- sram_wdata_o  out  RESULT_WIDTH  shared write data (registered)
- res_valid_o  out  1  accumulated result valid
- res_tag_o  out  TAG_WIDTH  tag of that result

## Operation
- FSM states: CLEAR and RUN. Reset enters CLEAR with clr_addr = 0.
- **CLEAR**
  - Each cycle drives en = we = all ones, all address slices = clr_addr, wdata = all ones (every rule matches).
  - clr_addr increments each cycle. At clr_addr = 2^STRIDE−1, the FSM moves to RUN and pulses clear_done_o in the following cycle.
  - Both ready outputs are 0. clear_i is ignored.
- **RUN, priority order per cycle:**
  1. clear_i = 1 → enter CLEAR next cycle. No grant is issued and both readies are 0.
  2. cfg_valid_i = 1, unless (lkp_valid_i = 1 and burst_cnt = MAX_CFG_BURST) → cfg grant.
  3. Otherwise lkp_valid_i = 1 → lookup grant.
- Readies are combinational from state, clear_i, burst_cnt and the other channel's valid. At most one grant per cycle.
- **cfg grant**
  - Only SRAM cfg_sram_i gets en = we = 1; its address slice is cfg_addr_i; wdata = cfg_data_i.
  - Other slices are 0 and other enables are 0.
  - cfg_sram_i ≥ SRAM_NUM is accepted and dropped (no enables).
- **lookup grant**
  - en = all ones, we = 0, address slice i = key slice i.
  - A valid bit and the tag enter a delay pipe.
- **burst_cnt**
  - Increments (saturating) on a cfg grant while lkp_valid_i = 1.
  - Cleared on a lookup grant, whenever lkp_valid_i = 0, and in CLEAR.
- Idle cycle: all en/we = 0. Address and wdata hold their values.
- Ordering: a lookup granted on any cycle after a cfg grant observes the new data. Same-cycle hazards cannot occur.

## Timing
- Lookup handshake at cycle T:
  - SRAM ports are driven at T+1.
  - Read data is valid at T+1+SRAM_LAT.
  - The accumulator registers it, so res_valid_o/res_tag_o are asserted at T+2+SRAM_LAT. This is 3 cycles with defaults.
- Throughput: one lookup per cycle when no cfg traffic is present.
- Delay pipe depth = SRAM_LAT+2, with valid bits reset to 0. Tags are not reset.
- Reset values: sram_en_o = sram_we_o = 0, sram_addr_o = 0, sram_wdata_o = 0, res_valid_o = 0, clear_done_o = 0, both readies = 0.
  - CLEAR drives en/we from the first post-reset cycle.
- Reset mid-clear or with lookups in flight: pipe valids are flushed, so no res_valid_o appears for pre-reset lookups, and the clear restarts from address 0.
- clear_i asserted with lookups in flight: in-flight results still emerge. The clear writes begin only after the last grant cycle.

## Structure
- Shared package bv_pkg holds the FSM state enum, the KEY_WIDTH/SEL_WIDTH derivations, and the all-ones clear pattern.
- One sub-module, bv_valid_pipe: a parameterised-depth valid+tag shift register with synchronous reset on valids only.

## Test plan
- Reset with defaults:
  - 16 cycles of en = we = 4'b1111, addr stepping 0..15, wdata = all ones.
  - clear_done_o pulses at cycle 17.
  - lkp_ready_o first rises the cycle after the clear ends.
- Back-to-back lookups, keys 0x3210, 0xFEDC, tags 1, 2:
  - sram_addr_o = 0x3210 then 0xFEDC.
  - res_valid_o on cycles T+3 and T+4 with tags 1 and 2.
- Simultaneous cfg and lookup held valid for 10 cycles: the grant pattern is 4 cfg, 1 lookup, 4 cfg, 1 lookup (no lookup starvation).
- cfg write SRAM 2, addr 5, data 0xA5..A5, then a lookup with key 0x0500:
  - The write cycle shows en = we = 4'b0100 and slice 2 = 5.
  - The lookup cycle shows we = 0 and en = 4'b1111.
- clear_i pulsed with 2 lookups in flight: both res_valid_o pulses appear, readies stay 0 for 16 cycles, then clear_done_o pulses.
- rst asserted at clear address 7 and during a lookup in flight: no res_valid_o appears, and the clear restarts at addr 0 for a full 16 cycles.

Source files
------------

// File: rtl/bv_pkg.sv
// ----------------------------------------------------------------------------
// bv_pkg
// Shared definitions for the bit-vector lookup controller slice.
//   - bvState_t   : controller FSM states (bank clear / normal run)
//   - CLEAR_BIT   : value replicated across a bit-vector during a bank clear
//   - keyWidth()  : total search key width from stride and SRAM count
//   - selWidth()  : width of the SRAM select field (never narrower than 1)
// No ports; imported by the interface and the top module.
// ----------------------------------------------------------------------------
package bv_pkg;

    typedef enum logic {
        StClear = 1'b0,
        StRun   = 1'b1
    } bvState_t;

    // A cleared entry matches every rule, so the clear pattern is all ones.
    localparam logic CLEAR_BIT = 1'b1;

    function automatic int keyWidth(input int stride, input int sramNum);
        return stride * sramNum;
    endfunction

    function automatic int selWidth(input int sramNum);
        return (sramNum > 1) ? $clog2(sramNum) : 1;
    endfunction

endpackage

// File: rtl/bv_lookup_ctrl_if.sv
// ----------------------------------------------------------------------------
// bv_lookup_ctrl_if
// Bundles every non-clock signal of the bit-vector lookup controller.
//   Lookup channel : lkp_valid_i, lkp_ready_o, lkp_key_i, lkp_tag_i
//   Update channel : cfg_valid_i, cfg_ready_o, cfg_sram_i, cfg_addr_i,
//                    cfg_data_i
//   Clear control  : clear_i, clear_done_o
//   SRAM bank side : sram_en_o, sram_we_o, sram_addr_o, sram_wdata_o
//   Result side    : res_valid_o, res_tag_o
// Modports: master = client driving requests, slave = the controller.
// ----------------------------------------------------------------------------
interface bv_lookup_ctrl_if #(
    parameter int STRIDE       = 4,
    parameter int SRAM_NUM     = 4,
    parameter int RESULT_WIDTH = 64,
    parameter int TAG_WIDTH    = 8
) ();
    import bv_pkg::*;

    localparam int KEY_WIDTH = keyWidth(STRIDE, SRAM_NUM);
    localparam int SEL_WIDTH = selWidth(SRAM_NUM);

    logic                    lkp_valid_i;
    logic                    lkp_ready_o;
    logic [KEY_WIDTH-1:0]    lkp_key_i;
    logic [TAG_WIDTH-1:0]    lkp_tag_i;

    logic                    cfg_valid_i;
    logic                    cfg_ready_o;
    logic [SEL_WIDTH-1:0]    cfg_sram_i;
    logic [STRIDE-1:0]       cfg_addr_i;
    logic [RESULT_WIDTH-1:0] cfg_data_i;

    logic                    clear_i;
    logic                    clear_done_o;

    logic [SRAM_NUM-1:0]     sram_en_o;
    logic [SRAM_NUM-1:0]     sram_we_o;
    logic [KEY_WIDTH-1:0]    sram_addr_o;
    logic [RESULT_WIDTH-1:0] sram_wdata_o;

    logic                    res_valid_o;
    logic [TAG_WIDTH-1:0]    res_tag_o;

    modport master (
        output lkp_valid_i, lkp_key_i, lkp_tag_i,
        output cfg_valid_i, cfg_sram_i, cfg_addr_i, cfg_data_i,
        output clear_i,
        input  lkp_ready_o, cfg_ready_o, clear_done_o,
        input  sram_en_o, sram_we_o, sram_addr_o, sram_wdata_o,
        input  res_valid_o, res_tag_o
    );

    modport slave (
        input  lkp_valid_i, lkp_key_i, lkp_tag_i,
        input  cfg_valid_i, cfg_sram_i, cfg_addr_i, cfg_data_i,
        input  clear_i,
        output lkp_ready_o, cfg_ready_o, clear_done_o,
        output sram_en_o, sram_we_o, sram_addr_o, sram_wdata_o,
        output res_valid_o, res_tag_o
    );

endinterface

// File: rtl/bv_valid_pipe.sv
// ----------------------------------------------------------------------------
// bv_valid_pipe
// Fixed-depth delay line carrying a valid bit and a tag, used to line up a
// lookup's tag with its accumulated match vector.
//   clk, rst : clock and synchronous active-high reset (clears valids only)
//   i_valid  : valid entering the pipe
//   i_tag    : tag entering the pipe
//   o_valid  : valid leaving the pipe DEPTH cycles later
//   o_tag    : tag leaving the pipe DEPTH cycles later
// ----------------------------------------------------------------------------
module bv_valid_pipe #(
    parameter int DEPTH     = 3,
    parameter int TAG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic [TAG_WIDTH-1:0] i_tag,
    output logic                 o_valid,
    output logic [TAG_WIDTH-1:0] o_tag
);

    logic [DEPTH-1:0]     r_valid;
    logic [TAG_WIDTH-1:0] r_tag [DEPTH];

    // Valid bits shift every cycle and are flushed by reset so that no
    // result ever appears for a lookup issued before the reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            r_valid <= {r_valid[DEPTH-2:0], i_valid};
        end
    end

    // Tags are qualified by their valid bit, so they follow the same shift
    // without a reset and carry no cost for the flush.
    always_ff @(posedge clk) begin
        r_tag[0] <= i_tag;
        for (int i = 1; i < DEPTH; i++) begin
            r_tag[i] <= r_tag[i-1];
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_tag   = r_tag[DEPTH-1];

endmodule

// File: rtl/bv_lookup_ctrl.sv
// ----------------------------------------------------------------------------
// bv_lookup_ctrl
// Arbitrates the single-port bit-vector SRAM bank between search lookups and
// rule-update writes, clears the whole bank after reset or on request, and
// tracks in-flight lookups so a valid/tag pair emerges with the accumulated
// match vector.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : bv_lookup_ctrl_if.slave -- lookup/update handshakes, clear
//         control, registered SRAM bank drive and the result valid/tag
// ----------------------------------------------------------------------------
module bv_lookup_ctrl #(
    parameter int STRIDE        = 4,
    parameter int SRAM_NUM      = 4,
    parameter int RESULT_WIDTH  = 64,
    parameter int SRAM_LAT      = 1,
    parameter int TAG_WIDTH     = 8,
    parameter int MAX_CFG_BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    bv_lookup_ctrl_if.slave bus
);
    import bv_pkg::*;

    localparam int KEY_WIDTH   = keyWidth(STRIDE, SRAM_NUM);
    localparam int BURST_WIDTH = $clog2(MAX_CFG_BURST + 1);
    localparam logic [BURST_WIDTH-1:0] BURST_MAX = BURST_WIDTH'(MAX_CFG_BURST);
    localparam logic [STRIDE-1:0]      CLR_LAST  = '1;

    bvState_t                r_state;
    bvState_t                w_nextState;
    logic [STRIDE-1:0]       r_clrAddr;
    logic [BURST_WIDTH-1:0]  r_burstCnt;
    logic                    r_clearEnd;
    logic                    r_clearDone;
    logic                    w_clearEnd;

    logic [SRAM_NUM-1:0]     r_en;
    logic [SRAM_NUM-1:0]     r_we;
    logic [KEY_WIDTH-1:0]    r_addr;
    logic [RESULT_WIDTH-1:0] r_wdata;
    logic [SRAM_NUM-1:0]     w_en;
    logic [SRAM_NUM-1:0]     w_we;
    logic [KEY_WIDTH-1:0]    w_addr;
    logic [RESULT_WIDTH-1:0] w_wdata;

    logic                    w_cfgReady;
    logic                    w_lkpReady;
    logic                    w_cfgGrant;
    logic                    w_lkpGrant;
    logic                    w_resValid;
    logic [TAG_WIDTH-1:0]    w_resTag;

    // State register plus all registered bookkeeping. The clear address only
    // advances while clearing and sits at zero otherwise, so every clear
    // starts from entry 0. The burst counter lets updates run ahead of a
    // waiting lookup for at most MAX_CFG_BURST grants. The clear-done pulse
    // is delayed one extra cycle so it lands after the last clear write has
    // appeared on the SRAM ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StClear;
            r_clrAddr   <= '0;
            r_burstCnt  <= '0;
            r_clearEnd  <= 1'b0;
            r_clearDone <= 1'b0;
            r_en        <= '0;
            r_we        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            r_state     <= w_nextState;
            r_clrAddr   <= (r_state == StClear) ? r_clrAddr + 1'b1 : '0;
            r_clearEnd  <= w_clearEnd;
            r_clearDone <= r_clearEnd;
            r_en        <= w_en;
            r_we        <= w_we;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            if (r_state != StRun || !bus.lkp_valid_i || w_lkpGrant) begin
                r_burstCnt <= '0;
            end else if (w_cfgGrant && r_burstCnt != BURST_MAX) begin
                r_burstCnt <= r_burstCnt + 1'b1;
            end
        end
    end

    // Next-state logic: a clear runs until the last entry is written, and a
    // clear request in RUN takes effect on the following cycle.
    always_comb begin
        w_nextState = r_state;
        w_clearEnd  = 1'b0;
        case (r_state)
            StClear: begin
                if (r_clrAddr == CLR_LAST) begin
                    w_nextState = StRun;
                    w_clearEnd  = 1'b1;
                end
            end
            StRun: begin
                if (bus.clear_i) begin
                    w_nextState = StClear;
                end
            end
            default: w_nextState = StClear;
        endcase
    end

    // Readies and grants. Updates normally win, but once the burst limit is
    // reached with a lookup waiting the lookup takes the slot. The two grant
    // conditions exclude each other, so the bank sees at most one access.
    always_comb begin
        w_cfgReady = 1'b0;
        w_lkpReady = 1'b0;
        if (r_state == StRun && !bus.clear_i) begin
            w_cfgReady = !(bus.lkp_valid_i && r_burstCnt == BURST_MAX);
            w_lkpReady = !bus.cfg_valid_i || r_burstCnt == BURST_MAX;
        end
        w_cfgGrant = bus.cfg_valid_i && w_cfgReady;
        w_lkpGrant = bus.lkp_valid_i && w_lkpReady;
    end

    // SRAM drive for the next cycle. Idle cycles drop the enables but keep
    // address and write data stable. An update to an out-of-range SRAM index
    // is accepted but produces no enable at all.
    always_comb begin
        w_en    = '0;
        w_we    = '0;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        if (r_state == StClear) begin
            w_en    = '1;
            w_we    = '1;
            w_addr  = {SRAM_NUM{r_clrAddr}};
            w_wdata = {RESULT_WIDTH{CLEAR_BIT}};
        end else if (w_cfgGrant) begin
            w_addr  = '0;
            w_wdata = bus.cfg_data_i;
            for (int i = 0; i < SRAM_NUM; i++) begin
                if (int'(bus.cfg_sram_i) == i) begin
                    w_en[i]                    = 1'b1;
                    w_we[i]                    = 1'b1;
                    w_addr[STRIDE*i +: STRIDE] = bus.cfg_addr_i;
                end
            end
        end else if (w_lkpGrant) begin
            w_en   = '1;
            w_addr = bus.lkp_key_i;
        end
    end

    bv_valid_pipe #(
        .DEPTH     (SRAM_LAT + 2),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_validPipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_lkpGrant),
        .i_tag   (bus.lkp_tag_i),
        .o_valid (w_resValid),
        .o_tag   (w_resTag)
    );

    assign bus.lkp_ready_o  = w_lkpReady;
    assign bus.cfg_ready_o  = w_cfgReady;
    assign bus.clear_done_o = r_clearDone;
    assign bus.sram_en_o    = r_en;
    assign bus.sram_we_o    = r_we;
    assign bus.sram_addr_o  = r_addr;
    assign bus.sram_wdata_o = r_wdata;
    assign bus.res_valid_o  = w_resValid;
    assign bus.res_tag_o    = w_resTag;

endmodule

// File: tb/tb_bv_lookup_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bv_lookup_ctrl
// Directed self-checking bench for bv_lookup_ctrl with default parameters.
// Inputs change 1 ns after a rising edge and outputs are read at that point.
// ----------------------------------------------------------------------------
module tb_bv_lookup_ctrl;

    localparam int STRIDE        = 4;
    localparam int SRAM_NUM      = 4;
    localparam int RESULT_WIDTH  = 64;
    localparam int SRAM_LAT      = 1;
    localparam int TAG_WIDTH     = 8;
    localparam int MAX_CFG_BURST = 4;

    localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] A5_64  = 64'hA5A5_A5A5_A5A5_A5A5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checkCount = 0;
    int   errorCount = 0;

    bv_lookup_ctrl_if #(
        .STRIDE       (STRIDE),
        .SRAM_NUM     (SRAM_NUM),
        .RESULT_WIDTH (RESULT_WIDTH),
        .TAG_WIDTH    (TAG_WIDTH)
    ) bus ();

    bv_lookup_ctrl #(
        .STRIDE        (STRIDE),
        .SRAM_NUM      (SRAM_NUM),
        .RESULT_WIDTH  (RESULT_WIDTH),
        .SRAM_LAT      (SRAM_LAT),
        .TAG_WIDTH     (TAG_WIDTH),
        .MAX_CFG_BURST (MAX_CFG_BURST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Safety net so the run always ends even if the sequence stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic lkpValid, input logic [15:0] key,
                                 input logic [7:0] lkpTag, input logic cfgValid,
                                 input logic [1:0] sram, input logic [3:0] addr,
                                 input logic [63:0] data, input logic clear);
        bus.lkp_valid_i = lkpValid;
        bus.lkp_key_i   = key;
        bus.lkp_tag_i   = lkpTag;
        bus.cfg_valid_i = cfgValid;
        bus.cfg_sram_i  = sram;
        bus.cfg_addr_i  = addr;
        bus.cfg_data_i  = data;
        bus.clear_i     = clear;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 2'd0, 4'd0, 64'h0, 1'b0);
    endtask

    // Expects a complete 16-entry clear starting right after the next edge,
    // followed by the done pulse one cycle after the last write.
    task automatic runClearCheck();
        logic [3:0] a;
        for (int k = 0; k < 16; k++) begin
            tick();
            a = 4'(k);
            checkOutput("clr_en", bus.sram_en_o, 4'hF);
            checkOutput("clr_we", bus.sram_we_o, 4'hF);
            checkOutput("clr_addr", bus.sram_addr_o, {a, a, a, a});
            checkOutput("clr_wdata", bus.sram_wdata_o, ONES64);
            checkOutput("clr_done_low", bus.clear_done_o, 1'b0);
            checkOutput("clr_res_low", bus.res_valid_o, 1'b0);
            if (k < 15) begin
                checkOutput("clr_lkp_ready", bus.lkp_ready_o, 1'b0);
            end
        end
        tick();
        checkOutput("clr_done_pulse", bus.clear_done_o, 1'b1);
        checkOutput("clr_end_en", bus.sram_en_o, 4'h0);
        checkOutput("clr_end_ready", bus.lkp_ready_o, 1'b1);
        tick();
        checkOutput("clr_done_drop", bus.clear_done_o, 1'b0);
    endtask

    initial begin
        logic isCfg;
        logic [3:0] a;
        idleInputs();

        // Reset values
        repeat (3) tick();
        checkOutput("rst_en", bus.sram_en_o, 4'h0);
        checkOutput("rst_we", bus.sram_we_o, 4'h0);
        checkOutput("rst_addr", bus.sram_addr_o, 16'h0);
        checkOutput("rst_wdata", bus.sram_wdata_o, 64'h0);
        checkOutput("rst_res_valid", bus.res_valid_o, 1'b0);
        checkOutput("rst_clear_done", bus.clear_done_o, 1'b0);
        checkOutput("rst_lkp_ready", bus.lkp_ready_o, 1'b0);
        checkOutput("rst_cfg_ready", bus.cfg_ready_o, 1'b0);
        rst = 1'b0;
        runClearCheck();

        // Back-to-back lookups
        applyStimulus(1'b1, 16'h3210, 8'd1, 1'b0, 2'd0, 4'd0, 64'h0, 1'b0);
        #1;
        checkOutput("b2b_ready", bus.lkp_ready_o, 1'b1);
        tick();
        checkOutput("b2b_addr0", bus.sram_addr_o, 16'h3210);
        checkOutput("b2b_en0", bus.sram_en_o, 4'hF);
        checkOutput("b2b_we0", bus.sram_we_o, 4'h0);
        checkOutput("b2b_res_early", bus.res_valid_o, 1'b0);
        applyStimulus(1'b1, 16'hFEDC, 8'd2, 1'b0, 2'd0, 4'd0, 64'h0, 1'b0);
        tick();
        checkOutput("b2b_addr1", bus.sram_addr_o, 16'hFEDC);
        checkOutput("b2b_res_early2", bus.res_valid_o, 1'b0);
        idleInputs();
        tick();
        checkOutput("b2b_res_valid0", bus.res_valid_o, 1'b1);
        checkOutput("b2b_res_tag0", bus.res_tag_o, 8'd1);
        tick();
        checkOutput("b2b_res_valid1", bus.res_valid_o, 1'b1);
        checkOutput("b2b_res_tag1", bus.res_tag_o, 8'd2);
        checkOutput("b2b_idle_en", bus.sram_en_o, 4'h0);
        checkOutput("b2b_idle_addr", bus.sram_addr_o, 16'hFEDC);
        tick();
        checkOutput("b2b_res_done", bus.res_valid_o, 1'b0);

        // Both channels held valid: four updates then one lookup, repeating
        applyStimulus(1'b1, 16'h0000, 8'd9, 1'b1, 2'd0, 4'd3, 64'h1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            isCfg = ((i % 5) != 4);
            checkOutput("arb_en", bus.sram_en_o, isCfg ? 4'b0001 : 4'b1111);
            checkOutput("arb_we", bus.sram_we_o, isCfg ? 4'b0001 : 4'b0000);
            checkOutput("arb_addr", bus.sram_addr_o, isCfg ? 16'h0003 : 16'h0000);
        end
        idleInputs();
        repeat (4) tick();

        // Single update to SRAM 2, then a lookup hitting the same entry
        applyStimulus(1'b0, 16'h0, 8'd0, 1'b1, 2'd2, 4'd5, A5_64, 1'b0);
        #1;
        checkOutput("cfg_ready", bus.cfg_ready_o, 1'b1);
        tick();
        checkOutput("cfg_en", bus.sram_en_o, 4'b0100);
        checkOutput("cfg_we", bus.sram_we_o, 4'b0100);
        checkOutput("cfg_addr", bus.sram_addr_o, 16'h0500);
        checkOutput("cfg_wdata", bus.sram_wdata_o, A5_64);
        applyStimulus(1'b1, 16'h0500, 8'd3, 1'b0, 2'd0, 4'd0, 64'h0, 1'b0);
        tick();
        checkOutput("cfg_lkp_en", bus.sram_en_o, 4'hF);
        checkOutput("cfg_lkp_we", bus.sram_we_o, 4'h0);
        checkOutput("cfg_lkp_addr", bus.sram_addr_o, 16'h0500);
        idleInputs();
        tick();
        tick();
        checkOutput("cfg_lkp_res", bus.res_valid_o, 1'b1);
        checkOutput("cfg_lkp_tag", bus.res_tag_o, 8'd3);
        tick();

        // Clear requested with two lookups in flight
        applyStimulus(1'b1, 16'h1111, 8'd4, 1'b0, 2'd0, 4'd0, 64'h0, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h2222, 8'd5, 1'b0, 2'd0, 4'd0, 64'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0, 8'd0, 1'b1, 2'd1, 4'd2, 64'h5, 1'b1);
        #1;
        checkOutput("clrq_lkp_ready", bus.lkp_ready_o, 1'b0);
        checkOutput("clrq_cfg_ready", bus.cfg_ready_o, 1'b0);
        for (int j = 1; j <= 16; j++) begin
            tick();
            checkOutput("clrq_lkp_ready_low", bus.lkp_ready_o, 1'b0);
            checkOutput("clrq_cfg_ready_low", bus.cfg_ready_o, 1'b0);
            checkOutput("clrq_done_low", bus.clear_done_o, 1'b0);
            if (j == 1) begin
                checkOutput("clrq_res0", bus.res_valid_o, 1'b1);
                checkOutput("clrq_tag0", bus.res_tag_o, 8'd4);
                checkOutput("clrq_no_grant", bus.sram_en_o, 4'h0);
                idleInputs();
            end
            if (j == 2) begin
                checkOutput("clrq_res1", bus.res_valid_o, 1'b1);
                checkOutput("clrq_tag1", bus.res_tag_o, 8'd5);
            end
            if (j >= 2) begin
                a = 4'(j - 2);
                checkOutput("clrq_en", bus.sram_en_o, 4'hF);
                checkOutput("clrq_addr", bus.sram_addr_o, {a, a, a, a});
            end
        end
        tick();
        checkOutput("clrq_last_addr", bus.sram_addr_o, 16'hFFFF);
        checkOutput("clrq_ready_back", bus.lkp_ready_o, 1'b1);
        checkOutput("clrq_done_low2", bus.clear_done_o, 1'b0);
        tick();
        checkOutput("clrq_done", bus.clear_done_o, 1'b1);
        checkOutput("clrq_idle_en", bus.sram_en_o, 4'h0);

        // Reset with a lookup in flight, then again partway through the clear
        applyStimulus(1'b1, 16'hABCD, 8'd6, 1'b0, 2'd0, 4'd0, 64'h0, 1'b0);
        tick();
        idleInputs();
        rst = 1'b1;
        tick();
        checkOutput("mrst_en", bus.sram_en_o, 4'h0);
        checkOutput("mrst_addr", bus.sram_addr_o, 16'h0);
        checkOutput("mrst_res", bus.res_valid_o, 1'b0);
        checkOutput("mrst_ready", bus.lkp_ready_o, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            a = 4'(k);
            checkOutput("mrst_clr_en", bus.sram_en_o, 4'hF);
            checkOutput("mrst_clr_addr", bus.sram_addr_o, {a, a, a, a});
            checkOutput("mrst_no_res", bus.res_valid_o, 1'b0);
        end
        rst = 1'b1;
        tick();
        checkOutput("mrst2_en", bus.sram_en_o, 4'h0);
        checkOutput("mrst2_addr", bus.sram_addr_o, 16'h0);
        checkOutput("mrst2_done", bus.clear_done_o, 1'b0);
        checkOutput("mrst2_res", bus.res_valid_o, 1'b0);
        rst = 1'b0;
        runClearCheck();

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
